ws2811_frame_sequencer: RTL and testbench
=========================================

// Module: ws2811_frame_sequencer
// PURPOSE
// - Upstream feeder for the WS2811 serial transmitter: walks a pixel RAM of LED_COUNT 24-bit RGB words.
// - Applies colour-order swizzle and global brightness, then hands one pixel at a time to the transmitter.
// - Enforces the line-low latch gap after the last pixel, then reports frame done.
// - Sits between the frame-buffer RAM (read port) and the transmitter (startIN/dataIN/busyOUT).
// PARAMETERS
// - CLOCK_SPEED  50_000_000  clkIN frequency, Hz
// - LED_COUNT    64          pixels per frame, >=1
// - RESET_US     60          latch gap after last pixel, us (>=50 for WS2811)
// - COLOR_ORDER  0           0: RGB out, 1: GRB out (WS2812 style)
// - ADDR_WIDTH   $clog2(LED_COUNT) (min 1)  pixel RAM address width
// PORTS
// - clkIN          in   1   system clock
// - resetIN        in   1   synchronous, active-high reset
// - frameStartIN   in   1   1-cycle pulse: send one full frame
// - brightnessIN   in   8   global brightness, sampled at frame start
// - pixAddrOUT     out  AW  pixel RAM read address
// - pixRdOUT       out  1   pixel RAM read strobe
// - pixDataIN      in   24  RAM read data {R,G,B}, valid 1 clk after pixRdOUT
// - txStartOUT     out  1   to transmitter startIN
// - txDataOUT      out  24  to transmitter dataIN, MSB first on wire
// - txBusyIN       in   1   from transmitter busyOUT
// - busyOUT        out  1   high from accepted frameStartIN until frameDoneOUT
// - frameDoneOUT   out  1   1-cycle pulse after latch gap completes
// - errorOUT       out  1   sticky: transmitter failed to acknowledge start
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; pixel index 0; errorOUT cleared only by resetIN.
// - States: IDLE -> DRAIN -> FETCH -> LOAD -> SEND -> WAIT_TX -> (FETCH | LATCH) -> DONE -> IDLE.
// - IDLE: frameStartIN accepted -> latch brightnessIN, index=0, busyOUT=1, go DRAIN; frameStartIN while busyOUT=1 ignored.
// - DRAIN: wait txBusyIN==0 (transmitter may still be finishing after a reset), then FETCH.
// - FETCH: pixAddrOUT=index, pixRdOUT=1 for exactly 1 clk -> LOAD.
// - LOAD: register pixDataIN; txDataOUT = swizzle(scale(R),scale(G),scale(B)); -> SEND.
// - scale(c) = (c * (bright+1)) >> 8, 8x9-bit product, truncated; bright=255 gives identity, 0 gives 0.
// - SEND: txStartOUT=1 held until txBusyIN sampled 1 (transmitter samples on falling edge), then 0 -> WAIT_TX.
// - SEND timeout: txBusyIN not seen within 8 clks -> errorOUT=1, txStartOUT=0, abort to LATCH.
// - WAIT_TX: wait txBusyIN==0; if index==LED_COUNT-1 -> LATCH, else index+1 -> FETCH; no wrap past LED_COUNT-1.
// - txDataOUT stable from LOAD until next LOAD; never changes while txStartOUT=1.
// - LATCH: counter LATCH_CYCLES = CLOCK_SPEED/1_000_000*RESET_US, down to 0; txStartOUT=0 throughout.
// - DONE: frameDoneOUT=1 one clk, busyOUT=0 the same clk, -> IDLE; back-to-back frameStartIN accepted next clk.
// - Per-pixel overhead: 3 clks + transmitter acknowledge, outside the 2.5 us bit period budget.
// - resetIN mid-frame: outputs to reset values next edge; in-flight transmitter pixel is absorbed by DRAIN.
// - frameStartIN coincident with resetIN: reset wins, request dropped.
// STRUCTURE
// - Package ws2811_pkg: state enum, colour-order constants, LATCH_CYCLES/timeout constants, 24-bit pixel typedef.
// - Sub-module ws2811_pixel_scaler: combinational brightness scale + swizzle, reused by later pattern blocks.
// - Latch counter width $clog2(LATCH_CYCLES+1).
// TESTING (CLOCK_SPEED=50M, LED_COUNT=3, RESET_US=50 -> 2500 clk gap; transmitter model answering busy after 1 clk)
// - RAM {FF0000,00FF00,0000FF}, bright=255, RGB -> txDataOUT FF0000,00FF00,0000FF in order, 3 starts, frameDoneOUT once.
// - Same frame, COLOR_ORDER=1, bright=127 -> 007F00,7F0000,00007F; bright=0 -> 000000 x3.
// - Latch: count clks from last txBusyIN fall to frameDoneOUT -> 2500 (+state overhead, +-1 clk), txStartOUT low throughout.
// - frameStartIN pulsed mid-frame -> ignored; pulse in clk after frameDoneOUT -> second frame starts, addresses 0,1,2.
// - Model never raises busy -> errorOUT=1 after 8 clks, frameDoneOUT after latch gap, errorOUT stays 1 until resetIN.
// - resetIN during pixel 1 with model busy -> outputs 0; new frame waits in DRAIN until busy drops, then restarts at addr 0.

Source files
------------

// File: rtl/ws2811_pkg.sv
// Shared types and constants for the WS2811 frame sequencer and its pixel datapath.
package ws2811_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_TX,
        ST_LATCH,
        ST_DONE
    } state_e;

    localparam int unsigned ORDER_RGB      = 0;
    localparam int unsigned ORDER_GRB      = 1;
    localparam int unsigned TX_ACK_TIMEOUT = 8;
    localparam int unsigned TMO_W          = $clog2(TX_ACK_TIMEOUT);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    function automatic int unsigned latch_cycles(input int unsigned clock_hz,
                                                 input int unsigned reset_us);
        return (clock_hz / 1_000_000) * reset_us;
    endfunction

    // 8x9-bit product so that bright=255 maps to identity and 0 to black.
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] bright);
        logic [16:0] prod;
        prod = 17'(c) * 17'({1'b0, bright} + 9'd1);
        return 8'(prod >> 8);
    endfunction

endpackage

// File: rtl/ws2811_pixel_scaler.sv
// Combinational global-brightness scale followed by the wire colour-order swizzle.
module ws2811_pixel_scaler
    import ws2811_pkg::*;
#(
    parameter int unsigned COLOR_ORDER = ORDER_RGB
) (
    input  logic [23:0] pix_i,
    input  logic [7:0]  bright_i,
    output logic [23:0] scaled_c_o
);

    pixel_t     pix;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;

    always_comb begin
        pix = pixel_t'(pix_i);
        r   = scale8(pix.r, bright_i);
        g   = scale8(pix.g, bright_i);
        b   = scale8(pix.b, bright_i);
        if (COLOR_ORDER == ORDER_GRB) begin
            scaled_c_o = {g, r, b};
        end else begin
            scaled_c_o = {r, g, b};
        end
    end

endmodule

// File: rtl/ws2811_frame_sequencer.sv
// Walks the pixel RAM, scales/swizzles each pixel, hands it to the WS2811 transmitter
// and holds the line low for the latch gap before reporting frame done.
module ws2811_frame_sequencer
    import ws2811_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED = 50_000_000,
    parameter int unsigned LED_COUNT   = 64,
    parameter int unsigned RESET_US    = 60,
    parameter int unsigned COLOR_ORDER = ORDER_RGB,
    parameter int unsigned ADDR_WIDTH  = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
    input  logic                  clkIN,
    input  logic                  resetIN,
    input  logic                  frameStartIN,
    input  logic [7:0]            brightnessIN,
    output logic [ADDR_WIDTH-1:0] pixAddrOUT,
    output logic                  pixRdOUT,
    input  logic [23:0]           pixDataIN,
    output logic                  txStartOUT,
    output logic [23:0]           txDataOUT,
    input  logic                  txBusyIN,
    output logic                  busyOUT,
    output logic                  frameDoneOUT,
    output logic                  errorOUT
);

    localparam int unsigned LATCH_CYCLES = latch_cycles(CLOCK_SPEED, RESET_US);
    localparam int unsigned LATCH_W      = (LATCH_CYCLES > 0) ? $clog2(LATCH_CYCLES + 1) : 1;
    localparam int unsigned LAST_IDX     = LED_COUNT - 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [7:0]            bright_q, bright_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [LATCH_W-1:0]    latch_q, latch_d;
    logic [ADDR_WIDTH-1:0] pix_addr_q, pix_addr_d;
    logic                  pix_rd_q, pix_rd_d;
    logic                  tx_start_q, tx_start_d;
    logic [23:0]           tx_data_q, tx_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [23:0]           scaled_c;
    logic                  last_pix_c;

    ws2811_pixel_scaler #(
        .COLOR_ORDER (COLOR_ORDER)
    ) u_scaler (
        .pix_i      (pixDataIN),
        .bright_i   (bright_q),
        .scaled_c_o (scaled_c)
    );

    assign last_pix_c = (index_q == ADDR_WIDTH'(LAST_IDX));

    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            bright_q   <= '0;
            tmo_q      <= '0;
            latch_q    <= '0;
            pix_addr_q <= '0;
            pix_rd_q   <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            bright_q   <= bright_d;
            tmo_q      <= tmo_d;
            latch_q    <= latch_d;
            pix_addr_q <= pix_addr_d;
            pix_rd_q   <= pix_rd_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // DRAIN lets a pixel still on the wire after a reset finish before we fetch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (frameStartIN) state_d = ST_DRAIN;
            ST_DRAIN:   if (!txBusyIN) state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_SEND;
            ST_SEND: begin
                if (txBusyIN) begin
                    state_d = ST_WAIT_TX;
                end else if (tmo_q == TMO_W'(TX_ACK_TIMEOUT - 1)) begin
                    state_d = ST_LATCH;
                end
            end
            ST_WAIT_TX: if (!txBusyIN) state_d = last_pix_c ? ST_LATCH : ST_FETCH;
            ST_LATCH:   if (latch_q == '0) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each registered strobe lines up with its state.
    always_comb begin
        index_d    = index_q;
        bright_d   = bright_q;
        tmo_d      = '0;
        latch_d    = latch_q;
        tx_data_d  = tx_data_q;
        error_d    = error_q;
        pix_addr_d = pix_addr_q;
        pix_rd_d   = (state_d == ST_FETCH);
        tx_start_d = (state_d == ST_SEND);
        busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (frameStartIN) begin
                    bright_d = brightnessIN;
                    index_d  = '0;
                end
            end
            ST_LOAD:    tx_data_d = scaled_c;
            ST_SEND: begin
                tmo_d = tmo_q + 1'b1;
                if (state_d == ST_LATCH) error_d = 1'b1;
            end
            ST_WAIT_TX: if (state_d == ST_FETCH) index_d = index_q + 1'b1;
            ST_LATCH:   if (latch_q != '0) latch_d = latch_q - 1'b1;
            default: ;
        endcase
        if ((state_d == ST_LATCH) && (state_q != ST_LATCH)) latch_d = LATCH_W'(LATCH_CYCLES);
        if (pix_rd_d) pix_addr_d = index_d;
    end

    assign pixAddrOUT   = pix_addr_q;
    assign pixRdOUT     = pix_rd_q;
    assign txStartOUT   = tx_start_q;
    assign txDataOUT    = tx_data_q;
    assign busyOUT      = busy_q;
    assign frameDoneOUT = done_q;
    assign errorOUT     = error_q;

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Scoreboard bench: RGB and GRB sequencers run in lockstep against a shared RAM image
// and identical transmitter models; a monitor checks every fetch and every start.
module tb_ws2811_frame_sequencer;

    localparam int M_NORMAL = 0;
    localparam int M_SILENT = 1;
    localparam int M_HOLD   = 2;
    localparam int BUSY_LEN = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [7:0]  bright = 8'd255;
    int          mode = M_NORMAL;

    logic [1:0]  addr_0, addr_1;
    logic        rd_0, rd_1;
    logic [23:0] rdata_0 = '0, rdata_1 = '0;
    logic        txs_0, txs_1;
    logic [23:0] txd_0, txd_1;
    logic        busy_in_0, busy_in_1;
    logic        busy_0, busy_1;
    logic        done_0, done_1;
    logic        err_0, err_1;
    int          bcnt_0 = 0, bcnt_1 = 0;
    logic [23:0] ram [0:3];

    always #5 clk = ~clk;

    ws2811_frame_sequencer #(
        .CLOCK_SPEED (50_000_000), .LED_COUNT (3), .RESET_US (50), .COLOR_ORDER (0)
    ) dut_rgb (
        .clkIN (clk), .resetIN (rst), .frameStartIN (frame_start), .brightnessIN (bright),
        .pixAddrOUT (addr_0), .pixRdOUT (rd_0), .pixDataIN (rdata_0),
        .txStartOUT (txs_0), .txDataOUT (txd_0), .txBusyIN (busy_in_0),
        .busyOUT (busy_0), .frameDoneOUT (done_0), .errorOUT (err_0)
    );

    ws2811_frame_sequencer #(
        .CLOCK_SPEED (50_000_000), .LED_COUNT (3), .RESET_US (50), .COLOR_ORDER (1)
    ) dut_grb (
        .clkIN (clk), .resetIN (rst), .frameStartIN (frame_start), .brightnessIN (bright),
        .pixAddrOUT (addr_1), .pixRdOUT (rd_1), .pixDataIN (rdata_1),
        .txStartOUT (txs_1), .txDataOUT (txd_1), .txBusyIN (busy_in_1),
        .busyOUT (busy_1), .frameDoneOUT (done_1), .errorOUT (err_1)
    );

    // RAM with one-clock read latency, and transmitters that raise busy one clock after start.
    always @(posedge clk) begin
        if (rd_0) rdata_0 <= ram[addr_0];
        if (rd_1) rdata_1 <= ram[addr_1];
        if (bcnt_0 != 0) begin
            if (mode != M_HOLD) bcnt_0 <= bcnt_0 - 1;
        end else if (txs_0 && mode == M_NORMAL) begin
            bcnt_0 <= BUSY_LEN;
        end
        if (bcnt_1 != 0) begin
            if (mode != M_HOLD) bcnt_1 <= bcnt_1 - 1;
        end else if (txs_1 && mode == M_NORMAL) begin
            bcnt_1 <= BUSY_LEN;
        end
    end
    assign busy_in_0 = (bcnt_0 != 0);
    assign busy_in_1 = (bcnt_1 != 0);

    int          total = 0;
    int          bad = 0;
    logic [47:0] exp_pix[$];
    logic [1:0]  exp_addr[$];
    logic [47:0] cur_exp = '0;
    logic        ps0 = 1'b0;
    logic        pb0 = 1'b0;
    int          cyc = 0;
    int          fall_cyc = 0;
    int          starts_since_fall = 0;
    int          start_cnt = 0;
    int          done_cnt = 0;
    int          start_w = 0;
    int          last_start_w = 0;
    int          latch_gap = 0;
    int          latch_starts = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon_step();
        logic [47:0] e;
        logic [1:0]  a;
        cyc++;
        if (txs_0 && !ps0) begin
            start_cnt++;
            starts_since_fall++;
            chk("start_lockstep", {47'd0, txs_1}, 48'd1);
            if (exp_pix.size() == 0) begin
                chk("unexpected_start", {txd_0, txd_1}, 48'hFFFF_FFFF_FFFF);
            end else begin
                e = exp_pix.pop_front();
                cur_exp = e;
                chk("tx_pixel", {txd_0, txd_1}, e);
            end
        end else if (txs_0 && ps0) begin
            chk("txdata_held", {txd_0, txd_1}, cur_exp);
        end
        if (txs_0) start_w++;
        if (!txs_0 && ps0) begin
            last_start_w = start_w;
            start_w = 0;
        end
        if (rd_0) begin
            chk("rd_lockstep", {47'd0, rd_1}, 48'd1);
            if (exp_addr.size() == 0) begin
                chk("unexpected_fetch", {46'd0, addr_0}, 48'hFFFF);
            end else begin
                a = exp_addr.pop_front();
                chk("fetch_addr", {44'd0, addr_0, addr_1}, {44'd0, a, a});
            end
        end
        if (pb0 && !busy_in_0) begin
            fall_cyc = cyc;
            starts_since_fall = 0;
        end
        if (done_0) begin
            done_cnt++;
            latch_gap = cyc - fall_cyc;
            latch_starts = starts_since_fall;
            chk("done_lockstep_busy_low", {45'd0, done_1, busy_0, busy_1}, 48'b100);
        end
        ps0 = txs_0;
        pb0 = busy_in_0;
    endtask

    task automatic push_frame(input logic [23:0] r0, r1, r2, g0, g1, g2);
        exp_pix.push_back({r0, g0});
        exp_pix.push_back({r1, g1});
        exp_pix.push_back({r2, g2});
        for (int i = 0; i < 3; i++) exp_addr.push_back(2'(i));
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < 8000) begin
            @(posedge clk);
            n++;
        end
        chk(name, {47'd0, done_cnt != base}, 48'd1);
    endtask

    task automatic frame_check(input int sbase, input logic [1:0] err_exp);
        chk("starts_per_frame", 48'(start_cnt - sbase), 48'd3);
        chk("latch_gap_range", {47'd0, (latch_gap >= 2500 && latch_gap <= 2504)}, 48'd1);
        chk("latch_no_start", 48'(latch_starts), 48'd0);
        chk("error_flags", {46'd0, err_0, err_1}, {46'd0, err_exp});
    endtask

    initial begin
        int sbase;
        int n;
        ram[0] = 24'hFF0000; ram[1] = 24'h00FF00; ram[2] = 24'h0000FF; ram[3] = 24'h000000;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs_rgb", {17'd0, busy_0, done_0, err_0, txs_0, rd_0, txd_0, addr_0}, 48'd0);
        chk("reset_outs_grb", {17'd0, busy_1, done_1, err_1, txs_1, rd_1, txd_1, addr_1}, 48'd0);
        #1 rst = 1'b0;

        // Full brightness, identity scale.
        bright = 8'd255;
        push_frame(24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h00FF00, 24'hFF0000, 24'h0000FF);
        sbase = start_cnt;
        pulse_start();
        wait_done("frame_b255_done");
        frame_check(sbase, 2'b00);

        bright = 8'd127;
        push_frame(24'h7F0000, 24'h007F00, 24'h00007F, 24'h007F00, 24'h7F0000, 24'h00007F);
        sbase = start_cnt;
        pulse_start();
        wait_done("frame_b127_done");
        frame_check(sbase, 2'b00);

        // Black frame with a stray start pulse mid-frame that must be ignored.
        bright = 8'd0;
        push_frame(24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
        sbase = start_cnt;
        pulse_start();
        repeat (10) @(posedge clk);
        pulse_start();
        wait_done("frame_b0_done");
        frame_check(sbase, 2'b00);

        // Back-to-back start in the clock after frame done; brightness is latched at accept.
        push_frame(24'hC80000, 24'h00C800, 24'h0000C8, 24'h00C800, 24'hC80000, 24'h0000C8);
        sbase = start_cnt;
        bright = 8'd200;
        #1 frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        bright = 8'd0;
        @(negedge clk);
        chk("b2b_accepted", {46'd0, busy_0, busy_1}, 48'b11);
        wait_done("frame_b2b_done");
        frame_check(sbase, 2'b00);

        // Transmitter never acknowledges.
        mode = M_SILENT;
        bright = 8'd255;
        exp_pix.push_back({24'hFF0000, 24'h00FF00});
        exp_addr.push_back(2'd0);
        sbase = start_cnt;
        pulse_start();
        wait_done("frame_timeout_done");
        chk("timeout_starts", 48'(start_cnt - sbase), 48'd1);
        chk("timeout_start_width", 48'(last_start_w), 48'd8);
        chk("timeout_error", {46'd0, err_0, err_1}, 48'b11);

        mode = M_NORMAL;
        push_frame(24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h00FF00, 24'hFF0000, 24'h0000FF);
        sbase = start_cnt;
        pulse_start();
        wait_done("frame_after_err_done");
        frame_check(sbase, 2'b11);

        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("error_cleared_by_reset", {46'd0, err_0, err_1}, 48'd0);

        // Reset while pixel 1 is on the wire, with a start request coincident with reset.
        exp_pix.push_back({24'hFF0000, 24'h00FF00});
        exp_pix.push_back({24'h00FF00, 24'hFF0000});
        exp_addr.push_back(2'd0);
        exp_addr.push_back(2'd1);
        sbase = start_cnt;
        pulse_start();
        n = 0;
        while (!(start_cnt >= sbase + 2 && busy_in_0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("pix1_in_flight", {47'd0, (start_cnt >= sbase + 2 && busy_in_0)}, 48'd1);
        mode = M_HOLD;
        @(posedge clk);
        #1 rst = 1'b1;
        frame_start = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        frame_start = 1'b0;
        @(negedge clk);
        chk("midframe_reset_rgb", {17'd0, busy_0, done_0, err_0, txs_0, rd_0, txd_0, addr_0}, 48'd0);
        chk("midframe_reset_grb", {17'd0, busy_1, done_1, err_1, txs_1, rd_1, txd_1, addr_1}, 48'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("start_with_reset_dropped", {46'd0, busy_0, busy_1}, 48'd0);

        push_frame(24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h00FF00, 24'hFF0000, 24'h0000FF);
        sbase = start_cnt;
        pulse_start();
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("drain_holds_fetch", 48'(exp_addr.size()), 48'd3);
        chk("drain_busy_high", {46'd0, busy_0, busy_1}, 48'b11);
        mode = M_NORMAL;
        wait_done("frame_after_drain_done");
        frame_check(sbase, 2'b00);

        repeat (5) @(posedge clk);
        chk("pixels_all_seen", 48'(exp_pix.size()), 48'd0);
        chk("fetches_all_seen", 48'(exp_addr.size()), 48'd0);
        chk("frames_done", 48'(done_cnt), 48'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
